io_bridge_serdes: RTL and testbench

//  Parametrised successor to the byte-serial TinyTapeOut IO controller. It moves CPU words over a narrow pin bus, BEATS = WORD_W/PIN_W beats per word.
//  Per CPU step: fetch one instruction word, pulse cpu_clk once, then optionally send an address/data word, then optionally read a word back.

---
 rtl/io_bridge_serdes.sv | 198 +++++++++++++++++++
 tb/tb_io_bridge_serdes.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge_serdes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : io_bridge_serdes                                                  |
// | Moves CPU words over a narrow pin bus, one PIN_W-bit beat at a time.       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module io_bridge_serdes #(
  parameter int WORD_W  = 32,
  parameter int PIN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIN_W-1:0]  pin_in,
  input  logic              pin_in_valid,
  output logic [PIN_W-1:0]  pin_addr_out,
  output logic [PIN_W-1:0]  pin_data_out,
  output logic              pin_out_valid,
  input  logic              pin_out_ready,
  input  logic              mem_w,
  input  logic              mem_r,
  input  logic              jump,
  input  logic              branch_success,
  input  logic [WORD_W-1:0] memory_address,
  input  logic [WORD_W-1:0] data_from_register,
  input  logic [WORD_W-1:0] jump_address,
  output logic              cpu_clk,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] memory_out,
  output logic              mem_done,
  output logic              busy,
  output logic              err
);

  localparam int c_beats = WORD_W / PIN_W;
  localparam int c_bw    = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam int c_sw    = $clog2(TIMEOUT + 2);
  localparam logic [c_bw-1:0] c_last      = c_bw'(c_beats - 1);
  localparam logic [c_sw-1:0] c_stall_max = c_sw'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              c_tmo_en    = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_SEND  = 3'd3,
    S_TURN  = 3'd4,
    S_READ  = 3'd5
  } state_t;

  state_t            r_state;
  logic [c_bw-1:0]   r_beat;
  logic [c_sw-1:0]   r_stall;
  logic [WORD_W-1:0] r_shadow;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data;
  logic              r_rd;

  logic [c_bw-1:0]   w_beat_nx;
  logic [WORD_W-1:0] w_shadow_next;
  logic [WORD_W-1:0] w_addr_sel;
  logic              w_any;
  logic              w_timeout;

  assign w_beat_nx  = r_beat + 1'b1;
  assign w_addr_sel = (jump | branch_success) ? jump_address : memory_address;
  assign w_any      = mem_w | mem_r | jump | branch_success;
  // Evaluated only on a stalled cycle: this stall is the TIMEOUT-th in a row.
  assign w_timeout  = c_tmo_en && (r_stall == c_stall_max);

  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[r_beat*PIN_W +: PIN_W] = pin_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_beat        <= '0;
      r_stall       <= '0;
      r_shadow      <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_rd          <= 1'b0;
      pin_addr_out  <= '0;
      pin_data_out  <= '0;
      pin_out_valid <= 1'b0;
      cpu_clk       <= 1'b0;
      instruction   <= '0;
      memory_out    <= '0;
      mem_done      <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      cpu_clk  <= 1'b0;
      mem_done <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_beat  <= '0;
          r_stall <= '0;
          busy    <= 1'b1;
          r_state <= S_FETCH;
        end
        S_FETCH, S_READ: begin
          if (pin_in_valid) begin
            r_shadow <= w_shadow_next;
            r_stall  <= '0;
            if (r_beat == c_last) begin
              r_beat <= '0;
              if (r_state == S_FETCH) begin
                instruction <= w_shadow_next;
                cpu_clk     <= 1'b1;
                r_state     <= S_EXEC;
              end else begin
                memory_out <= w_shadow_next;
                mem_done   <= 1'b1;
                busy       <= 1'b0;
                r_state    <= S_IDLE;
              end
            end else begin
              r_beat <= w_beat_nx;
            end
          end else if (w_timeout) begin
            r_stall <= '0;
            r_beat  <= '0;
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_stall <= r_stall + 1'b1;
          end
        end
        S_EXEC: begin
          r_rd    <= mem_r;
          r_addr  <= w_addr_sel;
          r_data  <= data_from_register;
          r_stall <= '0;
          r_beat  <= '0;
          if (w_any) begin
            pin_out_valid <= 1'b1;
            pin_addr_out  <= w_addr_sel[PIN_W-1:0];
            pin_data_out  <= data_from_register[PIN_W-1:0];
            r_state       <= S_SEND;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (pin_out_ready) begin
            r_stall <= '0;
            if (r_beat == c_last) begin
              r_beat        <= '0;
              pin_out_valid <= 1'b0;
              pin_data_out  <= '0;
              if (r_rd) begin
                pin_addr_out <= '1;
                r_state      <= S_TURN;
              end else begin
                pin_addr_out <= '0;
                busy         <= 1'b0;
                r_state      <= S_IDLE;
              end
            end else begin
              r_beat       <= w_beat_nx;
              pin_addr_out <= r_addr[w_beat_nx*PIN_W +: PIN_W];
              pin_data_out <= r_data[w_beat_nx*PIN_W +: PIN_W];
            end
          end else if (w_timeout) begin
            r_stall       <= '0;
            r_beat        <= '0;
            pin_out_valid <= 1'b0;
            pin_addr_out  <= '0;
            pin_data_out  <= '0;
            err           <= 1'b1;
            busy          <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_stall <= r_stall + 1'b1;
          end
        end
        S_TURN: begin
          pin_addr_out <= '0;
          r_stall      <= '0;
          r_beat       <= '0;
          r_state      <= S_READ;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_bridge_serdes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_io_bridge_serdes                                               |
// | Phase-level reference model of io_bridge_serdes with per-cycle compare.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_io_bridge_serdes;

  localparam int WORD_W = 32;
  localparam int PIN_W  = 8;
  localparam int TMO    = 4;
  localparam int BEATS  = WORD_W / PIN_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PIN_W-1:0]  pin_in;
  logic              pin_in_valid;
  logic [PIN_W-1:0]  pin_addr_out;
  logic [PIN_W-1:0]  pin_data_out;
  logic              pin_out_valid;
  logic              pin_out_ready;
  logic              mem_w, mem_r, jump, branch_success;
  logic [WORD_W-1:0] memory_address, data_from_register, jump_address;
  logic              cpu_clk;
  logic [WORD_W-1:0] instruction, memory_out;
  logic              mem_done, busy, err;

  io_bridge_serdes #(.WORD_W(WORD_W), .PIN_W(PIN_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .pin_in(pin_in), .pin_in_valid(pin_in_valid),
    .pin_addr_out(pin_addr_out), .pin_data_out(pin_data_out),
    .pin_out_valid(pin_out_valid), .pin_out_ready(pin_out_ready),
    .mem_w(mem_w), .mem_r(mem_r), .jump(jump), .branch_success(branch_success),
    .memory_address(memory_address), .data_from_register(data_from_register),
    .jump_address(jump_address), .cpu_clk(cpu_clk), .instruction(instruction),
    .memory_out(memory_out), .mem_done(mem_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cpu_pulses = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle, set by the phase model below.
  bit          e_busy, e_cpu, e_pv, e_done, e_err;
  logic [7:0]  e_pa, e_pd;
  logic [31:0] e_instr, e_mem;
  logic [31:0] m_instr, m_mem;
  bit          pend_done, pend_err;

  bit          valid_q[$];
  bit          ready_q[$];
  logic [15:0] sent_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",          32'(busy),          32'(e_busy));
      check("cpu_clk",       32'(cpu_clk),       32'(e_cpu));
      check("pin_out_valid", 32'(pin_out_valid), 32'(e_pv));
      check("pin_addr_out",  32'(pin_addr_out),  32'(e_pa));
      check("pin_data_out",  32'(pin_data_out),  32'(e_pd));
      check("mem_done",      32'(mem_done),      32'(e_done));
      check("err",           32'(err),           32'(e_err));
      check("instruction",   instruction,        e_instr);
      check("memory_out",    memory_out,         e_mem);
      if (pin_out_valid && pin_out_ready) sent_q.push_back({pin_addr_out, pin_data_out});
      if (cpu_clk) cpu_pulses++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic bit next_valid();
    if (valid_q.size() > 0) return valid_q.pop_front();
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic bit next_ready();
    if (ready_q.size() > 0) return ready_q.pop_front();
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_junk();
    pin_in             = 8'($urandom);
    pin_in_valid       = 1'($urandom);
    pin_out_ready      = 1'($urandom);
    mem_w              = 1'($urandom);
    mem_r              = 1'($urandom);
    jump               = 1'($urandom);
    branch_success     = 1'($urandom);
    memory_address     = $urandom;
    data_from_register = $urandom;
    jump_address       = $urandom;
  endtask

  task automatic set_exp(input bit b, input bit c, input bit pv, input logic [7:0] pa, input logic [7:0] pd);
    e_busy = b; e_cpu = c; e_pv = pv; e_pa = pa; e_pd = pd;
    e_done = 1'b0; e_err = 1'b0;
    e_instr = m_instr; e_mem = m_mem;
  endtask

  task automatic idle_cycle();
    drive_junk();
    set_exp(0, 0, 0, 8'h00, 8'h00);
    e_done = pend_done; e_err = pend_err;
    pend_done = 1'b0; pend_err = 1'b0;
    next_cycle();
  endtask

  // Inbound word; status 0 = complete, 1 = timed out, 2 = stopped at abort_at beats.
  task automatic beat_in(input logic [31:0] w, input int abort_at, output int status);
    int k; int stalls; bit v;
    k = 0; stalls = 0;
    while (1) begin
      if (k == abort_at) begin status = 2; return; end
      drive_junk();
      set_exp(1, 0, 0, 8'h00, 8'h00);
      v = next_valid();
      pin_in_valid = v;
      if (v) pin_in = w[8*k +: 8];
      next_cycle();
      if (v) begin
        k++; stalls = 0;
        if (k == BEATS) begin status = 0; return; end
      end else begin
        stalls++;
        if (stalls == TMO) begin pend_err = 1'b1; status = 1; return; end
      end
    end
  endtask

  task automatic send_phase(input logic [31:0] a, input logic [31:0] d, output int status);
    int k; int stalls; bit r;
    k = 0; stalls = 0;
    while (1) begin
      drive_junk();
      set_exp(1, 0, 1, a[8*k +: 8], d[8*k +: 8]);
      r = next_ready();
      pin_out_ready = r;
      next_cycle();
      if (r) begin
        k++; stalls = 0;
        if (k == BEATS) begin status = 0; return; end
      end else begin
        stalls++;
        if (stalls == TMO) begin pend_err = 1'b1; status = 1; return; end
      end
    end
  endtask

  task automatic cpu_step(input logic [31:0] iw, input bit mw, input bit mr, input bit j, input bit b,
                          input logic [31:0] maddr, input logic [31:0] mdata, input logic [31:0] jaddr,
                          input logic [31:0] rword, input int rst_at);
    int st;
    idle_cycle();
    beat_in(iw, -1, st);
    if (st != 0) return;
    m_instr = iw;
    drive_junk();
    set_exp(1, 1, 0, 8'h00, 8'h00);
    mem_w = mw; mem_r = mr; jump = j; branch_success = b;
    memory_address = maddr; data_from_register = mdata; jump_address = jaddr;
    next_cycle();
    if (!(mw | mr | j | b)) return;
    send_phase((j | b) ? jaddr : maddr, mdata, st);
    if (st != 0 || !mr) return;
    drive_junk();
    set_exp(1, 0, 0, 8'hFF, 8'h00);
    next_cycle();
    beat_in(rword, rst_at, st);
    if (st == 0) begin
      m_mem = rword; pend_done = 1'b1;
    end else if (st == 2) begin
      drive_junk();
      set_exp(1, 0, 0, 8'h00, 8'h00);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      m_instr = '0; m_mem = '0; pend_done = 1'b0; pend_err = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] st_exp [4];
    logic [31:0] sent_addr;
    logic [31:0] rw;
    st_exp = '{16'hDD44, 16'hCC33, 16'hBB22, 16'hAA11};
    m_instr = '0; m_mem = '0; pend_done = 1'b0; pend_err = 1'b0;
    drive_junk();
    rst = 1'b1;
    @(posedge clk); #1;
    set_exp(0, 0, 0, 8'h00, 8'h00);
    chk_en = 1'b1;
    next_cycle();
    rst = 1'b0;

    // No-op step
    valid_q = '{1, 1, 1, 1};
    cpu_pulses = 0;
    cpu_step(32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    check("noop_instr", instruction, 32'h12345678);
    check("noop_cpu_pulses", 32'(cpu_pulses), 32'd1);

    // Store with ready stalled two cycles on beat 1
    valid_q = '{1, 1, 1, 1};
    ready_q = '{1, 0, 0, 1, 1, 1};
    sent_q.delete();
    cpu_step(32'h01020304, 1, 0, 0, 0, 32'hAABBCCDD, 32'h11223344, 32'h0, 32'h0, -1);
    check("store_beats", 32'(sent_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < sent_q.size(); i++) check("store_beat", 32'(sent_q[i]), 32'(st_exp[i]));

    // Load
    valid_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    ready_q = '{1, 1, 1, 1};
    cpu_step(32'h0A0B0C0D, 0, 1, 0, 0, 32'h00001000, 32'h0, 32'h0, 32'hDEADBEEF, -1);
    check("load_memory_out", memory_out, 32'hDEADBEEF);
    check("load_mem_done", 32'(mem_done), 32'd1);

    // Jump alongside mem_r: jump target is the sent address
    valid_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    ready_q = '{1, 1, 1, 1};
    sent_q.delete();
    cpu_step(32'h0BADC0DE, 0, 1, 1, 0, 32'h12340000, 32'h5A5A5A5A, 32'h00400010, 32'h76543210, -1);
    sent_addr = '0;
    for (int i = 0; i < 4 && i < sent_q.size(); i++) sent_addr[8*i +: 8] = sent_q[i][15:8];
    check("jump_addr", sent_addr, 32'h00400010);
    check("jump_read", memory_out, 32'h76543210);

    // Fetch timeout after two beats
    valid_q = '{1, 1, 0, 0, 0, 0};
    cpu_step(32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_instr_kept", instruction, 32'h0BADC0DE);
    valid_q = '{1, 1, 1, 1};
    cpu_step(32'h55AA33CC, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    check("restart_instr", instruction, 32'h55AA33CC);

    // Reset mid-READ after two beats
    valid_q = '{1, 1, 1, 1, 1, 1};
    ready_q = '{1, 1, 1, 1};
    cpu_step(32'h13579BDF, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_memory_out", memory_out, 32'd0);
    check("rst_instr", instruction, 32'd0);

    // Randomized steps
    for (int n = 0; n < 250; n++) begin
      rw = $urandom;
      cpu_step($urandom, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 3) == 0), $urandom, $urandom, $urandom, rw, -1);
    end
    idle_cycle();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
